// File: rtl/tinker_run_pkg.sv
// Shared types and default timing constants for the tinker_core run controller,
// also used by the core-level bench and the FPGA top.
package tinker_run_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET_HOLD,
        RUN,
        HALTED,
        TIMEOUT
    } run_state_t;

    localparam int DEFAULT_RESET_CYCLES   = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 100;
    localparam int DEFAULT_CNT_W          = 32;

    // Only a running or halted core is let out of reset; a halted core stays
    // out of reset so its state can be inspected.
    function automatic logic core_held_in_reset(input run_state_t s);
        return !((s == RUN) || (s == HALTED));
    endfunction

endpackage

// File: rtl/tinker_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones
// instead of wrapping.
module tinker_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            count_reg <= '0;
        end else if (en && !(&count_reg)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/tinker_run_ctrl.sv
// Run controller for tinker_core: holds the core in reset, releases it, then
// watches hlt until halt, timeout or abort while counting run cycles.
module tinker_run_ctrl
    import tinker_run_pkg::*;
#(
    parameter int RESET_CYCLES   = DEFAULT_RESET_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             core_hlt,
    output logic             core_reset,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_CYCLES - 1);
    // Count value on the cycle whose increment reaches the timeout limit.
    localparam logic [CNT_W-1:0] LAST_RUN_COUNT =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    run_state_t        state_reg, state_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              core_reset_reg, core_reset_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              timed_out_reg, timed_out_next;
    logic              cnt_clear;
    logic              cnt_en;
    logic [CNT_W-1:0]  count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            hold_reg       <= '0;
            core_reset_reg <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            timed_out_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hold_reg       <= hold_next;
            core_reset_reg <= core_reset_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            timed_out_reg  <= timed_out_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        case (state_reg)
            IDLE, HALTED, TIMEOUT: begin
                if (start) begin
                    state_next = RESET_HOLD;
                    hold_next  = HOLD_LOAD;
                    cnt_clear  = 1'b1;
                end
            end
            RESET_HOLD: begin
                // core_hlt is meaningless while the core is held in reset.
                if (abort) begin
                    state_next = IDLE;
                end else if (hold_reg == '0) begin
                    state_next = RUN;
                end else begin
                    hold_next = hold_reg - HOLD_W'(1);
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (core_hlt) begin
                    state_next = HALTED;
                end else begin
                    cnt_en = 1'b1;
                    if ((TIMEOUT_CYCLES != 0) && (count == LAST_RUN_COUNT)) begin
                        state_next = TIMEOUT;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge.
    always_comb begin
        core_reset_next = core_held_in_reset(state_next);
        busy_next       = (state_next == RESET_HOLD) || (state_next == RUN);
        done_next       = (state_next == HALTED);
        timed_out_next  = (state_next == TIMEOUT);
    end

    tinker_sat_counter #(
        .W(CNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .srst  (reset),
        .clear (cnt_clear),
        .en    (cnt_en),
        .count (count)
    );

    assign core_reset  = core_reset_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign timed_out   = timed_out_reg;
    assign cycle_count = count;

endmodule

// File: tb/tb_tinker_run_ctrl.sv
// Bench for tinker_run_ctrl: directed and random runs against an outcome model
// derived from the halt / abort / timeout priority rules.
module tb_tinker_run_ctrl;

    localparam int RA    = 2;
    localparam int TO_A  = 100;
    localparam int NONE  = 100000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default timing
    logic        reset, start, abort, core_hlt;
    logic        core_reset, busy, done, timed_out;
    logic [31:0] cycle_count;

    // Instance B: 4-bit counter, timeout disabled, single reset cycle
    logic        reset_b, start_b, abort_b, core_hlt_b;
    logic        core_reset_b, busy_b, done_b, timed_out_b;
    logic [3:0]  cycle_count_b;

    int total = 0;
    int bad   = 0;

    tinker_run_ctrl #(.RESET_CYCLES(RA), .TIMEOUT_CYCLES(TO_A), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .core_hlt(core_hlt),
        .core_reset(core_reset), .busy(busy), .done(done), .timed_out(timed_out),
        .cycle_count(cycle_count)
    );

    tinker_run_ctrl #(.RESET_CYCLES(1), .TIMEOUT_CYCLES(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .abort(abort_b), .core_hlt(core_hlt_b),
        .core_reset(core_reset_b), .busy(busy_b), .done(done_b), .timed_out(timed_out_b),
        .cycle_count(cycle_count_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic cr, input logic bz, input logic dn,
                           input logic tmo, input int cnt);
        check({tag, ".core_reset"}, 64'(core_reset), 64'(cr));
        check({tag, ".busy"}, 64'(busy), 64'(bz));
        check({tag, ".done"}, 64'(done), 64'(dn));
        check({tag, ".timed_out"}, 64'(timed_out), 64'(tmo));
        check({tag, ".cycle_count"}, 64'(cycle_count), 64'(cnt));
    endtask

    // One full run on instance A. hlt_at / abort_at are the run-cycle indices
    // (cycles already counted) at which core_hlt / abort are presented.
    task automatic do_run(input string tag, input int hlt_at, input int abort_at,
                          input bit hlt_in_hold);
        int n;
        int k;
        int exp_cnt;
        bit exp_cr, exp_done, exp_to;
        if (abort_at <= hlt_at && abort_at < TO_A) begin
            exp_cnt = abort_at; exp_cr = 1; exp_done = 0; exp_to = 0;
        end else if (hlt_at < TO_A) begin
            exp_cnt = hlt_at;   exp_cr = 0; exp_done = 1; exp_to = 0;
        end else begin
            exp_cnt = TO_A;     exp_cr = 1; exp_done = 0; exp_to = 1;
        end

        start = 1'b1;
        core_hlt = hlt_in_hold;
        tick;
        start = 1'b0;
        check_a({tag, ".start"}, 1'b1, 1'b1, 1'b0, 1'b0, 0);

        n = 0;
        while (core_reset === 1'b1 && n < 20) begin
            n++;
            tick;
        end
        check({tag, ".hold_len"}, 64'(n), 64'(RA));

        k = 0;
        while (busy === 1'b1 && k < 400) begin
            core_hlt = (k == hlt_at);
            abort    = (k == abort_at);
            start    = 1'($urandom_range(0, 1));
            tick;
            k++;
            if (busy === 1'b1) check({tag, ".run_count"}, 64'(cycle_count), 64'(k));
        end
        start = 1'b0;
        abort = 1'b0;
        core_hlt = 1'b0;
        check_a({tag, ".end"}, exp_cr, 1'b0, exp_done, exp_to, exp_cnt);
        $display("run %s hlt_at=%0d abort_at=%0d hold=%0d -> done=%0d timed_out=%0d count=%0d",
                 tag, hlt_at, abort_at, n, done, timed_out, cycle_count);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ha;
        int aa;
        reset = 1'b1; start = 1'b0; abort = 1'b0; core_hlt = 1'b0;
        reset_b = 1'b1; start_b = 1'b0; abort_b = 1'b0; core_hlt_b = 1'b0;

        // 1: reset for 3 cycles
        repeat (3) tick;
        check_a("reset", 1'b1, 1'b0, 1'b0, 1'b0, 0);
        reset = 1'b0;
        reset_b = 1'b0;
        tick;
        check_a("idle", 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // 2: halt 12 cycles into RUN
        do_run("halt12", 12, NONE, 1'b0);
        // restart from HALTED, 3: timeout
        do_run("timeout", NONE, NONE, 1'b0);
        // halt on the would-be timeout cycle wins
        do_run("halt_vs_to", TO_A - 1, NONE, 1'b0);
        // 4: hlt during reset hold ignored, seen on first RUN cycle
        do_run("hlt_in_hold", 0, NONE, 1'b1);
        // 5: abort at RUN cycle 5 (start also toggled randomly during RUN)
        do_run("abort5", 40, 5, 1'b0);

        // start+abort while idle: start wins; abort in RESET_HOLD returns to IDLE
        start = 1'b1; abort = 1'b1;
        tick;
        check_a("idle_start_abort", 1'b1, 1'b1, 1'b0, 1'b0, 0);
        start = 1'b0;
        tick;
        check_a("hold_abort", 1'b1, 1'b0, 1'b0, 1'b0, 0);
        abort = 1'b0;
        $display("directed idle start+abort then abort in hold -> busy=%0d", busy);

        // Random runs
        for (int i = 0; i < 16; i++) begin
            ha = $urandom_range(0, 130);
            aa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 120) : NONE;
            do_run($sformatf("rand%0d", i), ha, aa, 1'($urandom_range(0, 1)));
        end

        // 6a: reset at RUN cycle 7
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (RA) tick;
        repeat (7) tick;
        check_a("pre_reset_run", 1'b0, 1'b1, 1'b0, 1'b0, 7);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_a("mid_run_reset", 1'b1, 1'b0, 1'b0, 1'b0, 0);
        $display("directed reset at RUN cycle 7 -> core_reset=%0d count=%0d", core_reset, cycle_count);

        // 6b: saturating count with timeout disabled
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        check("b.start.busy", 64'(busy_b), 64'(1));
        check("b.start.core_reset", 64'(core_reset_b), 64'(1));
        tick;
        check("b.run.core_reset", 64'(core_reset_b), 64'(0));
        for (int j = 1; j <= 25; j++) begin
            tick;
            check("b.sat_count", 64'(cycle_count_b), 64'((j > 15) ? 15 : j));
        end
        check("b.no_timeout", 64'(timed_out_b), 64'(0));
        check("b.still_busy", 64'(busy_b), 64'(1));
        core_hlt_b = 1'b1;
        tick;
        core_hlt_b = 1'b0;
        check("b.done", 64'(done_b), 64'(1));
        check("b.final_count", 64'(cycle_count_b), 64'(15));
        $display("run b saturate -> done=%0d timed_out=%0d count=%0d", done_b, timed_out_b, cycle_count_b);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
